// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU.
// Returns {HI,LO} through the hi/lo/whilo path and stalls EX while busy.
module ex_muldiv #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              annul_i,
  output logic              stallreq_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o,
  output logic              dbz_o
);

  localparam int W  = DATA_W;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q, b_q, rem_q;
  logic [2*W-1:0]  acc_q;
  logic [CW-1:0]   cnt_q;
  logic            qneg_q, rneg_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            dbz_q;

  logic            accept, div_op, sdiv;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic            mul_last, div_last;
  logic            msgn;
  logic [2*W-1:0]  ax, bx, prod, mul_res;
  logic [W:0]      shl, dif;
  logic            ge;

  assign accept   = (state_q == S_IDLE) & start_i & ~annul_i;
  assign div_op   = (op_i[2:1] == 2'b01);
  assign sdiv     = (op_i == 3'd2);
  assign a_neg    = sdiv & opa_i[W-1];
  assign b_neg    = sdiv & opb_i[W-1];
  assign a_mag    = a_neg ? -opa_i : opa_i;
  assign b_mag    = b_neg ? -opb_i : opb_i;
  assign mul_last = (cnt_q == CW'(MUL_STAGES - 1));
  assign div_last = (cnt_q == CW'(W));

  // Even opcodes multiply signed; odd ones unsigned.
  assign msgn = ~op_q[0];
  assign ax   = {{W{msgn & a_q[W-1]}}, a_q};
  assign bx   = {{W{msgn & b_q[W-1]}}, b_q};
  assign prod = ax * bx;

  always_comb begin
    mul_res = prod;
    if (op_q[2]) begin
      mul_res = op_q[1] ? (acc_q - prod) : (acc_q + prod);
    end
  end

  // a_q doubles as the dividend/quotient shift register.
  assign shl = {rem_q, a_q[W-1]};
  assign dif = shl - {1'b0, b_q};
  assign ge  = ~dif[W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = div_op ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (mul_last) begin
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (b_q == '0 || div_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op_i;
            acc_q  <= {hi_i, lo_i};
            cnt_q  <= '0;
            rem_q  <= '0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (div_op) begin
              a_q <= (opb_i == '0) ? opa_i : a_mag;
              b_q <= b_mag;
            end else begin
              a_q <= opa_i;
              b_q <= opb_i;
            end
          end
        end
        S_MUL: begin
          cnt_q <= cnt_q + CW'(1);
          if (state_d == S_DONE) begin
            {hi_q, lo_q} <= mul_res;
          end
        end
        S_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (state_d == S_DONE) begin
            if (b_q == '0) begin
              hi_q  <= a_q;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else begin
              hi_q <= rneg_q ? -rem_q : rem_q;
              lo_q <= qneg_q ? -a_q : a_q;
            end
          end else if (!div_last) begin
            rem_q <= ge ? dif[W-1:0] : shl[W-1:0];
            a_q   <= {a_q[W-2:0], ge};
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign stallreq_o = accept | (state_q == S_MUL) | (state_q == S_DIV);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign whilo_o    = done_o & ~annul_i;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign dbz_o      = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: arithmetic reference model plus per-cycle compare.
// Directed vectors carry hand-computed results that pin the model.
module tb_ex_muldiv;

  localparam int W  = 32;
  localparam int MS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  opa = '0, opb = '0, hii = '0, loi = '0;
  logic          annul = 1'b0;
  logic          stall, busy, done, whilo, dbz;
  logic [W-1:0]  hio, loo;

  ex_muldiv #(.DATA_W(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op),
    .opa_i(opa), .opb_i(opb), .hi_i(hii), .lo_i(loi),
    .annul_i(annul), .stallreq_o(stall), .busy_o(busy),
    .done_o(done), .hi_o(hio), .lo_o(loo),
    .whilo_o(whilo), .dbz_o(dbz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected busy window [blo,bhi], done cycle dcyc, result.
  int           blo = -1, bhi = -1, dcyc = -1, cur_lat = 0;
  logic [W-1:0] ehi = '0, elo = '0;
  logic         edbz = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]   o,
    input  logic [W-1:0] a, b, h, l,
    output logic [W-1:0] rh, rl,
    output logic         z,
    output int           lat);
    longint      sa, sb;
    logic [63:0] p, r;
    z = 1'b0;
    if (o == 3'd2 || o == 3'd3) begin
      if (b == '0) begin
        rh = a; rl = '1; z = 1'b1; lat = 1;
      end else begin
        if (o == 3'd2) begin
          sa = $signed(a); sb = $signed(b);
        end else begin
          sa = {32'b0, a}; sb = {32'b0, b};
        end
        rl  = 32'(sa / sb);
        rh  = 32'(sa % sb);
        lat = W + 1;
      end
    end else begin
      if (o[0]) begin
        p = {32'b0, a} * {32'b0, b};
      end else begin
        sa = $signed(a); sb = $signed(b);
        p  = 64'(sa * sb);
      end
      r = {h, l};
      if (o == 3'd4 || o == 3'd5)      r = r + p;
      else if (o == 3'd6 || o == 3'd7) r = r - p;
      else                             r = p;
      rh  = r[63:32];
      rl  = r[31:0];
      lat = MS;
    end
  endfunction

  always @(negedge clk) begin
    bit bz, dn, st;
    bz = (blo >= 0) && (cyc >= blo) && (cyc <= bhi);
    dn = (cyc == dcyc);
    st = (bz && !dn) || (!bz && start && !annul);
    chk("busy",  64'(busy),  64'(bz));
    chk("stall", 64'(stall), 64'(st));
    chk("done",  64'(done),  64'(dn));
    chk("whilo", 64'(whilo), 64'(dn && !annul));
    chk("hi",    64'(hio),   dn ? 64'(ehi) : 64'd0);
    chk("lo",    64'(loo),   dn ? 64'(elo) : 64'd0);
    chk("dbz",   64'(dbz),   dn ? 64'(edbz) : 64'd0);
  end

  task automatic start_op(input logic [2:0] o,
                          input logic [W-1:0] a, b, h, l);
    @(posedge clk); #1;
    op = o; opa = a; opb = b; hii = h; loi = l; start = 1'b1;
    model(o, a, b, h, l, ehi, elo, edbz, cur_lat);
    blo  = cyc + 1;
    bhi  = cyc + 1 + cur_lat;
    dcyc = bhi;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input string nm, input logic [2:0] o,
                     input logic [W-1:0] a, b, h, l,
                     input bit lit, input logic [W-1:0] xh, xl,
                     input logic xz);
    start_op(o, a, b, h, l);
    if (lit) begin
      chk({nm, "_res"}, {ehi, elo}, {xh, xl});
      chk({nm, "_dbz"}, 64'(edbz), 64'(xz));
    end
    repeat (cur_lat) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hio, loo}, 64'd0);
    rst = 1'b0;

    run("mult",  3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run("div",   3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run("divu",  3'd3, 32'd100, 32'd7, 0, 0, 1, 32'd2, 32'd14, 0);
    run("dovf",  3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 32'h80000000, 0);
    run("dbzu",  3'd3, 32'd100, 32'd0, 0, 0, 1, 32'h64, 32'hFFFFFFFF, 1);
    run("dbzs",  3'd2, 32'hFFFFFFF9, 32'd0, 0, 0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    run("madd",  3'd4, 32'd3, 32'hFFFFFFFE, 0, 32'h10, 1, 32'h0, 32'hA, 0);
    run("msubu", 3'd7, 32'd1, 32'd1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run("div_pn", 3'd2, 32'd7, 32'hFFFFFFFE, 0, 0, 1, 32'd1, 32'hFFFFFFFD, 0);
    run("div_nn", 3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0, 1, 32'hFFFFFFFF, 32'd3, 0);
    run("msub",  3'd6, 32'd2, 32'd3, 0, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run("multu", 3'd1, 32'h10000, 32'h10000, 0, 0, 1, 32'd1, 32'd0, 0);
    run("maddu", 3'd5, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 1, 32'd2, 32'd0, 0);
    run("div0",  3'd2, 32'd0, 32'd5, 0, 0, 1, 32'd0, 32'd0, 0);
    run("divbig", 3'd3, 32'h12345678, 32'h1234, 0, 0, 0, 0, 0, 0);
    run("multbig", 3'd0, 32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0);

    // A request flushed in the same cycle must not be accepted.
    @(posedge clk); #1;
    op = 3'd3; opa = 32'd9; opb = 32'd3; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    chk("annul_req_busy", 64'(busy), 64'd0);

    start_op(3'd3, 32'd1000, 32'd3, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    bhi   = cyc;
    dcyc  = -1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_busy", 64'(busy), 64'd0);
    run("divu93", 3'd3, 32'd9, 32'd3, 0, 0, 1, 32'd0, 32'd3, 0);

    start_op(3'd3, 32'hFFFFFFFF, 32'd3, 0, 0);
    repeat (5) @(posedge clk);
    #3;
    blo = -1; bhi = -1; dcyc = -1;
    rst = 1'b1;
    #1;
    chk("arst_busy",  64'(busy),  64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_done",  64'(done),  64'd0);
    chk("arst_hilo",  {hio, loo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1,
        32'hFFFFFFFE, 32'h00000001, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit beside the EX-stage ALU. It executes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU and returns a 2×DATA_W {HI,LO} result to ex_mem through the existing hi/lo/whilo path. It requests a pipeline stall for as long as an operation is in flight. It supports flush (annul) and reports divide-by-zero.

Parameters:
DATA_W, 32, operand width; HI/LO are DATA_W each.
MUL_STAGES, 2, multiply latency in cycles (1..4), from acceptance edge to the done_o cycle.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  operation request from EX; held while EX stalls
op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
opa_i  in  DATA_W  rs operand (multiplicand / dividend)
opb_i  in  DATA_W  rt operand (multiplier / divisor)
hi_i  in  DATA_W  forwarded HI (accumulate ops)
lo_i  in  DATA_W  forwarded LO (accumulate ops)
annul_i  in  1  flush: abort current or requested operation
stallreq_o  out  1  stall request to ctrl
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle result-valid pulse
hi_o  out  DATA_W  result HI (remainder for divide)
lo_o  out  DATA_W  result LO (quotient for divide)
whilo_o  out  1  HI/LO write enable to ex_mem
dbz_o  out  1  divide-by-zero flag, valid with done_o

Behaviour:
- States: IDLE, MUL, DIV, DONE. rst=1 forces IDLE immediately (async) and sets all registered outputs to 0: done_o, whilo_o, dbz_o, hi_o, lo_o = 0.
- Acceptance happens on a rising edge in IDLE with start_i=1 and annul_i=0. At that edge the unit captures op_i, opa_i, opb_i, hi_i and lo_i. Ops 0,1,4..7 go to MUL; ops 2,3 go to DIV.
- Multiply: full 2×DATA_W product, signed for ops 0,4,6 and unsigned for 1,5,7. The MUL state lasts MUL_STAGES cycles. For MADD*/MSUB*, the result is captured {hi_i,lo_i} ± product, modulo 2^(2·DATA_W).
- Divide: restoring algorithm on magnitudes, one quotient bit per cycle, DATA_W iterations. done_o asserts DATA_W+1 cycles after the acceptance edge.
  - Signed division: quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Overflow (most-negative / −1) gives LO = most-negative, HI = 0.
- Divide by zero (opb_i==0): no iteration. DONE is entered on the next edge with LO = all ones, HI = opa_i and dbz_o = 1.
- DONE lasts exactly one cycle: done_o=1, and whilo_o=1 unless annul_i=1 in that cycle. hi_o/lo_o are valid only in that cycle; dbz_o=0 for all other operations. The state then returns to IDLE, and start_i is ignored during DONE.
- stallreq_o is combinational: (IDLE & start_i & ~annul_i) | MUL | DIV. It is 0 in DONE so the instruction advances with its result.
- annul_i=1 in MUL or DIV aborts to IDLE on the next edge with no done_o and no whilo_o. A new start is accepted on the edge after that.
- Outside DONE: hi_o = lo_o = 0 and whilo_o = 0.

Test Plan:
- MULT, DATA_W=32, MUL_STAGES=2, opa=0xFFFFFFFD (−3), opb=5 -> done_o 2 cycles after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFF1; whilo_o=1 for exactly 1 cycle; stallreq_o=1 from the request cycle until done.
- DIV opa=0xFFFFFFF9 (−7), opb=2 -> done_o at cycle 33 after acceptance; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with DIVU 100/7 -> LO=14, HI=2.
- DIV opa=0x80000000, opb=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/0 -> done_o after 1 cycle, dbz_o=1, LO=0xFFFFFFFF, HI=0x00000064.
- MADD with hi_i=0, lo_i=0x10, opa=3, opb=0xFFFFFFFE -> {HI,LO}=0x00000000_0000000A. MSUBU with hi_i=0, lo_i=0, opa=1, opb=1 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF.
- Start DIVU, then assert annul_i at cycle 10 -> no done_o/whilo_o, busy_o=0 next cycle. Then DIVU 9/3 -> LO=3, HI=0, dbz_o=0.
- Assert rst asynchronously mid-divide (between edges) -> busy_o, stallreq_o and outputs go to 0 immediately. After release, MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
